// File: rtl/cft_reset_pkg.sv
// Shared types and defaults for the processor reset sequencer.
// Holds the sequencer state enum, parameter defaults and counter sizing.
package cft_reset_pkg;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        REL_BUS  = 3'd1,
        REL_REGS = 3'd2,
        BOOT     = 3'd3,
        RUN      = 3'd4,
        FAIL     = 3'd5
    } rseq_state_t;

    localparam int STAGE_CYCLES_DEF = 16;
    localparam int ACK_TIMEOUT_DEF  = 1024;

    // Wide enough for the larger terminal value, with one spare bit.
    function automatic int rseq_cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/reset_stage_counter.sv
// Clear/enable counter that saturates at a programmable terminal value.
// Ports: clk, rst (async high), clr, en, term -> count, at_term.
module reset_stage_counter
    import cft_reset_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         at_term
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign at_term = (count_q == term);
    assign count   = count_q;

    // Clear wins over enable; counting stops at the terminal value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !at_term) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Releases bus, register file and control unit resets in order, then
// runs the boot handshake. Ports: clk, reset, resetting, boot_ack ->
// rst_bus, rst_regs, rst_ctl, boot_req, running, boot_fail.
module reset_sequencer
    import cft_reset_pkg::*;
#(
    parameter int STAGE_CYCLES = STAGE_CYCLES_DEF,
    parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic resetting,
    input  logic boot_ack,
    output logic rst_bus,
    output logic rst_regs,
    output logic rst_ctl,
    output logic boot_req,
    output logic running,
    output logic boot_fail
);

    localparam int CW = rseq_cnt_width(STAGE_CYCLES, ACK_TIMEOUT);
    localparam logic [CW-1:0] STAGE_TERM = CW'(STAGE_CYCLES - 1);
    localparam logic [CW-1:0] ACK_TERM   = CW'(ACK_TIMEOUT - 1);

    rseq_state_t state_q, state_d;

    logic          cnt_clr;
    logic          cnt_en;
    logic [CW-1:0] cnt_term;
    logic [CW-1:0] cnt_val;
    logic          cnt_at_term;

    logic rst_bus_q, rst_bus_d;
    logic rst_regs_q, rst_regs_d;
    logic rst_ctl_q, rst_ctl_d;
    logic boot_req_q, boot_req_d;
    logic running_q, running_d;
    logic boot_fail_q, boot_fail_d;

    reset_stage_counter #(
        .W(CW)
    ) u_cnt (
        .clk    (clk),
        .rst    (reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .term   (cnt_term),
        .count  (cnt_val),
        .at_term(cnt_at_term)
    );

    always_comb begin
        state_d  = state_q;
        cnt_en   = 1'b0;
        cnt_term = STAGE_TERM;
        unique case (state_q)
            HOLD: begin
                cnt_en = 1'b1;
                if (cnt_at_term) state_d = REL_BUS;
            end
            REL_BUS: begin
                cnt_en = 1'b1;
                if (cnt_at_term) state_d = REL_REGS;
            end
            REL_REGS: begin
                cnt_en = 1'b1;
                if (cnt_at_term) state_d = BOOT;
            end
            BOOT: begin
                cnt_en   = 1'b1;
                cnt_term = ACK_TERM;
                // Ack beats a timeout landing on the same edge.
                if (boot_ack) begin
                    state_d = RUN;
                end else if (cnt_at_term) begin
                    state_d = FAIL;
                end
            end
            RUN:     state_d = RUN;
            FAIL:    state_d = FAIL;
            default: state_d = HOLD;
        endcase

        // resetting overrides every other transition.
        if (resetting) state_d = HOLD;

        // Every stage starts counting from zero.
        cnt_clr = resetting || (state_d != state_q);

        // Outputs are registered images of the next state.
        rst_bus_d   = (state_d == HOLD);
        rst_regs_d  = (state_d == HOLD) || (state_d == REL_BUS);
        rst_ctl_d   = !((state_d == BOOT) || (state_d == RUN));
        boot_req_d  = (state_d == BOOT);
        running_d   = (state_d == RUN);
        boot_fail_d = (state_d == FAIL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HOLD;
            rst_bus_q   <= 1'b1;
            rst_regs_q  <= 1'b1;
            rst_ctl_q   <= 1'b1;
            boot_req_q  <= 1'b0;
            running_q   <= 1'b0;
            boot_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_bus_q   <= rst_bus_d;
            rst_regs_q  <= rst_regs_d;
            rst_ctl_q   <= rst_ctl_d;
            boot_req_q  <= boot_req_d;
            running_q   <= running_d;
            boot_fail_q <= boot_fail_d;
        end
    end

    assign rst_bus   = rst_bus_q;
    assign rst_regs  = rst_regs_q;
    assign rst_ctl   = rst_ctl_q;
    assign boot_req  = boot_req_q;
    assign running   = running_q;
    assign boot_fail = boot_fail_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer.
// Expected outputs come from the edge-number timing rules of the sequence.
`timescale 1ns/1ps
module tb_reset_sequencer;

    localparam int S = 16;
    localparam int T = 1024;
    localparam logic [5:0] RST_VALS = 6'b111000;

    logic clk;
    logic reset;
    logic resetting;
    logic boot_ack;
    logic rst_bus;
    logic rst_regs;
    logic rst_ctl;
    logic boot_req;
    logic running;
    logic boot_fail;

    int total;
    int bad;

    reset_sequencer #(
        .STAGE_CYCLES(S),
        .ACK_TIMEOUT (T)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .resetting(resetting),
        .boot_ack (boot_ack),
        .rst_bus  (rst_bus),
        .rst_regs (rst_regs),
        .rst_ctl  (rst_ctl),
        .boot_req (boot_req),
        .running  (running),
        .boot_fail(boot_fail)
    );

    initial clk = 1'b0;
    always #125 clk = ~clk;

    function automatic logic [5:0] outs();
        return {rst_bus, rst_regs, rst_ctl, boot_req, running, boot_fail};
    endfunction

    // Output vector after edge e of a release (edge 0 = first edge that
    // sees resetting low); ack_k = edge where a valid ack was taken.
    function automatic logic [5:0] model(input int e, input int ack_k);
        int boot_e;
        int tmo_e;
        boot_e = 3 * S - 1;
        tmo_e  = 3 * S - 1 + T;
        if (ack_k >= 0 && e >= ack_k) return 6'b000010;
        if (e >= tmo_e)               return 6'b001001;
        if (e >= boot_e)              return 6'b000100;
        if (e >= 2 * S - 1)           return 6'b001000;
        if (e >= S - 1)               return 6'b011000;
        return 6'b111000;
    endfunction

    // One held edge, then n_edges with resetting low. Optional one-edge
    // resetting pulse at the end (with or without a coincident ack).
    task automatic run_release(input int n_edges, input int ack_from,
                               input bit noise, input bit abort,
                               input bit ack_on_abort, input string name);
        int ack_k;
        logic [5:0] exp_v;
        logic [5:0] got;
        resetting = 1'b1;
        boot_ack  = 1'b0;
        @(negedge clk);
        total++;
        if (outs() !== RST_VALS) begin
            bad++;
            $display("FAIL %s_hold: got %b want %b", name, outs(), RST_VALS);
        end
        ack_k = -1;
        for (int e = 0; e < n_edges; e++) begin
            resetting = 1'b0;
            if (ack_from >= 0 && e >= ack_from) begin
                boot_ack = 1'b1;
            end else if (noise && e < 3 * S) begin
                boot_ack = 1'($urandom % 2);
            end else begin
                boot_ack = 1'b0;
            end
            if (boot_ack && ack_k < 0 && e >= 3 * S && e <= 3 * S - 1 + T)
                ack_k = e;
            @(negedge clk);
            exp_v = model(e, ack_k);
            got   = outs();
            total++;
            if (got !== exp_v) begin
                bad++;
                if (bad < 20)
                    $display("FAIL %s edge %0d: got %b want %b",
                             name, e, got, exp_v);
            end
        end
        if (abort) begin
            resetting = 1'b1;
            boot_ack  = ack_on_abort;
            @(negedge clk);
            total++;
            if (outs() !== RST_VALS) begin
                bad++;
                $display("FAIL %s_abort: got %b want %b",
                         name, outs(), RST_VALS);
            end
        end
        resetting = 1'b1;
        boot_ack  = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        resetting = 1'b1;
        boot_ack  = 1'b0;
        #10;
        total++;
        if (outs() !== RST_VALS) begin
            bad++;
            $display("FAIL por_async: got %b want %b", outs(), RST_VALS);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            boot_ack = 1'($urandom % 2);
            @(negedge clk);
            total++;
            if (outs() !== RST_VALS) begin
                bad++;
                $display("FAIL por_hold %0d: got %b want %b",
                         i, outs(), RST_VALS);
            end
        end
        boot_ack = 1'b0;
    endtask

    task automatic test_nominal();
        run_release(3 * S + 12, 3 * S - 1 + 5, 1'b0, 1'b0, 1'b0, "nominal");
    endtask

    task automatic test_timeout();
        run_release(3 * S + T + 6, -1, 1'b1, 1'b0, 1'b0, "timeout");
        run_release(3 * S + 10, 3 * S + int'($urandom_range(0, 6)),
                    1'b0, 1'b0, 1'b0, "rerun");
    endtask

    task automatic test_abort();
        int a;
        a = int'($urandom_range(2 * S, 3 * S - 2));
        run_release(a + 1, -1, 1'b1, 1'b1, 1'b0, "abort_regs");
        run_release(3 * S + 10, 3 * S + int'($urandom_range(0, 4)),
                    1'b0, 1'b0, 1'b0, "after_abort");
        a = int'($urandom_range(1, S - 2));
        run_release(a, -1, 1'b0, 1'b1, 1'b0, "glitch_hold");
        run_release(3 * S + 8, 3 * S, 1'b0, 1'b0, 1'b0, "after_glitch");
    endtask

    task automatic test_simultaneous();
        run_release(3 * S - 1 + T + 4, 3 * S - 1 + T,
                    1'b0, 1'b0, 1'b0, "ack_at_tmo");
        run_release(3 * S + int'($urandom_range(0, 20)), -1,
                    1'b0, 1'b1, 1'b1, "ack_with_resetting");
    endtask

    task automatic test_async_reset();
        run_release(3 * S + 8, 3 * S + 2, 1'b0, 1'b0, 1'b0, "pre_async");
        #10;
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL async_pre: running got %b want 1", running);
        end
        reset = 1'b1;
        #1;
        total++;
        if (outs() !== RST_VALS) begin
            bad++;
            $display("FAIL async_reset: got %b want %b", outs(), RST_VALS);
        end
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (outs() !== RST_VALS) begin
            bad++;
            $display("FAIL async_after: got %b want %b", outs(), RST_VALS);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            int d;
            d = int'($urandom_range(0, 40));
            if ($urandom % 2 == 1) begin
                run_release(int'($urandom_range(1, 3 * S + 30)), 3 * S + d,
                            1'b1, 1'b1, 1'($urandom % 2), "b2b_abort");
            end else begin
                run_release(3 * S + d + 3, 3 * S + d,
                            1'b1, 1'b0, 1'b0, "b2b_run");
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_nominal();
        test_timeout();
        test_abort();
        test_simultaneous();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
